ps2_keyboard: RTL and testbench

Receives PS/2 keyboard frames and turns them into the `key_pressed`/`key_flag` pair consumed by the convolution `processor` controller, which uses it for kernel selection and start commands. The block has three layers:
- a synchronising bit-level receiver;
- a byte-level scan-code decoder that strips break (F0) and extended (E0) prefixes;
- suppression of typematic repeats, so the processor sees exactly one event per physical key press.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_frame_rx.sv | 115 +++++++++++
 rtl/ps2_keyboard.sv | 106 ++++++++++
 tb/tb_ps2_keyboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, frame-state encoding and parity helper for the PS/2 keyboard receiver.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam int         FRAME_BITS = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } frame_state_e;

   // bits[7:0] data, bits[8] odd parity, bits[9] stop
   function automatic logic frame_ok(input logic [FRAME_BITS-2:0] bits);
      return (^bits[8:0]) & bits[9];
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// Bit-level PS/2 receiver: input synchronisers, falling-edge detect, 11-bit frame FSM
// and mid-frame timeout. Emits one byte_valid or byte_err pulse per frame attempt.
import ps2_pkg::*;

module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [7:0]   byte_data,
   output logic         byte_valid,
   output logic         byte_err,
   output frame_state_e state
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);
   localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   frame_state_e           state_q, state_d;
   logic [3:0]             bitcnt_q, bitcnt_d;
   logic [FRAME_BITS-2:0]  shreg_q, shreg_d;
   logic [TW-1:0]          tocnt_q, tocnt_d;

   logic fall;
   logic data_s;

   always_comb begin
      clk_sync_d     = clk_sync_q;
      data_sync_d    = data_sync_q;
      clk_sync_d[0]  = ps2_clk;
      data_sync_d[0] = ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         clk_sync_d[i]  = clk_sync_q[i-1];
         data_sync_d[i] = data_sync_q[i-1];
      end
      clk_prev_d = clk_sync_q[SYNC_STAGES-1];
   end

   assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      tocnt_d    = tocnt_q;
      byte_valid = 1'b0;
      byte_err   = 1'b0;
      case (state_q)
         IDLE: begin
            tocnt_d = '0;
            if (fall && !data_s) begin
               state_d  = RECV;
               bitcnt_d = 4'd1;
               shreg_d  = '0;
            end
         end
         RECV: begin
            // a fall in the same cycle as the timeout wins and restarts the count
            if (fall) begin
               shreg_d  = {data_s, shreg_q[FRAME_BITS-2:1]};
               bitcnt_d = bitcnt_q + 4'd1;
               tocnt_d  = '0;
               if (bitcnt_q == STOP_IDX) state_d = CHECK;
            end else if (tocnt_q == TO_LAST) begin
               state_d  = IDLE;
               byte_err = 1'b1;
               tocnt_d  = '0;
               bitcnt_d = '0;
            end else begin
               tocnt_d = tocnt_q + TO_ONE;
            end
         end
         CHECK: begin
            if (frame_ok(shreg_q)) byte_valid = 1'b1;
            else                   byte_err   = 1'b1;
            state_d  = IDLE;
            bitcnt_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shreg_q     <= '0;
         tocnt_q     <= '0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shreg_q     <= shreg_d;
         tocnt_q     <= tocnt_d;
      end
   end

   assign byte_data = shreg_q[7:0];
   assign state     = state_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: frame receiver plus scan-code decoder that strips E0/F0
// prefixes and suppresses typematic repeats, giving one key_flag per physical press.
import ps2_pkg::*;

module ps2_keyboard #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_pressed,
   output logic       key_flag,
   output logic       frame_err,
   output logic [1:0] rx_state
);

   logic [7:0]   byte_data;
   logic         byte_valid;
   logic         byte_err;
   frame_state_e rx_fsm;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_frame_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_err   (byte_err),
      .state      (rx_fsm)
   );

   assign rx_state = rx_fsm;

   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic [7:0] held_q, held_d;
   logic       held_v_q, held_v_d;
   logic [7:0] key_pressed_q, key_pressed_d;
   logic       key_flag_q, key_flag_d;
   logic       frame_err_q, frame_err_d;

   always_comb begin
      brk_d         = brk_q;
      ext_d         = ext_q;
      held_d        = held_q;
      held_v_d      = held_v_q;
      key_pressed_d = key_pressed_q;
      key_flag_d    = 1'b0;
      frame_err_d   = 1'b0;
      if (byte_err) begin
         // a corrupt byte may have been the code after a prefix, so drop the prefixes
         brk_d       = 1'b0;
         ext_d       = 1'b0;
         frame_err_d = 1'b1;
      end else if (byte_valid) begin
         if (byte_data == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (byte_data == PS2_BREAK) begin
            brk_d = 1'b1;
         end else if (brk_q) begin
            if (held_v_q && byte_data == held_q) held_v_d = 1'b0;
            brk_d = 1'b0;
            ext_d = 1'b0;
         end else begin
            if (!(held_v_q && byte_data == held_q)) begin
               key_pressed_d = byte_data;
               key_flag_d    = 1'b1;
               held_d        = byte_data;
               held_v_d      = 1'b1;
            end
            ext_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         brk_q         <= 1'b0;
         ext_q         <= 1'b0;
         held_q        <= '0;
         held_v_q      <= 1'b0;
         key_pressed_q <= '0;
         key_flag_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         brk_q         <= brk_d;
         ext_q         <= ext_d;
         held_q        <= held_d;
         held_v_q      <= held_v_d;
         key_pressed_q <= key_pressed_d;
         key_flag_q    <= key_flag_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign key_pressed = key_pressed_q;
   assign key_flag    = key_flag_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: PS/2 frames at 12.5 kHz against a 1 MHz system clock.
module tb_ps2_keyboard;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_pressed;
   logic       key_flag;
   logic       frame_err;
   logic [1:0] rx_state;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int flag_cnt = 0;
   int err_cnt  = 0;
   int last_fall_cyc = 0;
   int last_flag_cyc = 0;
   int last_err_cyc  = 0;
   int f0, e0;
   logic [7:0]  exp_q[$];
   logic [31:0] want;

   // ---------------- clock / reset ----------------
   always #500 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_keyboard dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_pressed (key_pressed),
      .key_flag    (key_flag),
      .frame_err   (frame_err),
      .rx_state    (rx_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- drivers ----------------
   // one PS/2 bit: 80 system cycles = 12.5 kHz, data stable around the falling edge
   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (40) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (19) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
      ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 11);
   endtask

   task automatic mark();
      f0 = flag_cnt;
      e0 = err_cnt;
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         if (key_flag) begin
            flag_cnt++;
            last_flag_cyc = cyc;
            if (exp_q.size() > 0) want = {24'd0, exp_q.pop_front()};
            else                  want = 32'h100;
            check_eq("key_pressed_at_flag", {24'd0, key_pressed}, want);
         end
         if (frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
         end
         if (key_flag || frame_err)
            check_eq("flag_err_exclusive", {31'd0, key_flag & frame_err}, 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (5) @(negedge clk);
      check_eq("rst_key_pressed", {24'd0, key_pressed}, 32'h00);
      check_eq("rst_key_flag", {31'd0, key_flag}, 32'd0);
      check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b1;
      repeat (20) @(negedge clk);

      // single make code, parity bit 0
      mark();
      exp_q.push_back(8'h1C);
      send_byte(8'h1C);
      check_eq("s1_flag_latency", last_flag_cyc - last_fall_cyc, 32'd4);
      repeat (100) @(negedge clk);
      check_eq("s1_flags", flag_cnt - f0, 32'd1);
      check_eq("s1_errs", err_cnt - e0, 32'd0);
      check_eq("s1_key", {24'd0, key_pressed}, 32'h1C);

      // release, then press with typematic repeats and a release/re-press
      mark();
      send_byte(8'hF0);
      send_byte(8'h1C);
      exp_q.push_back(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      exp_q.push_back(8'h1C);
      send_byte(8'h1C);
      repeat (100) @(negedge clk);
      check_eq("s2_flags", flag_cnt - f0, 32'd2);
      check_eq("s2_errs", err_cnt - e0, 32'd0);
      check_eq("s2_key", {24'd0, key_pressed}, 32'h1C);

      // parity error then a good byte
      mark();
      send_frame(8'h1D, 1'b1, 11);
      repeat (100) @(negedge clk);
      check_eq("s3_err_flags", flag_cnt - f0, 32'd0);
      check_eq("s3_err_errs", err_cnt - e0, 32'd1);
      check_eq("s3_err_latency", last_err_cyc - last_fall_cyc, 32'd4);
      exp_q.push_back(8'h2D);
      send_byte(8'h2D);
      repeat (100) @(negedge clk);
      check_eq("s3_flags", flag_cnt - f0, 32'd1);
      check_eq("s3_key", {24'd0, key_pressed}, 32'h2D);

      // truncated frame, timeout abort, then recovery
      mark();
      send_frame(8'h5A, 1'b0, 5);
      repeat (50100) @(negedge clk);
      check_eq("s4_to_errs", err_cnt - e0, 32'd1);
      check_eq("s4_to_flags", flag_cnt - f0, 32'd0);
      check_eq("s4_to_cycle", last_err_cyc - last_fall_cyc, 32'd50003);
      check_eq("s4_to_state_idle", {30'd0, rx_state}, 32'd0);
      exp_q.push_back(8'h24);
      send_byte(8'h24);
      repeat (100) @(negedge clk);
      check_eq("s4_flags", flag_cnt - f0, 32'd1);
      check_eq("s4_key", {24'd0, key_pressed}, 32'h24);

      // extended make and break; a fresh press afterwards proves the release
      mark();
      exp_q.push_back(8'h75);
      send_byte(8'hE0);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      repeat (100) @(negedge clk);
      check_eq("s5_flags", flag_cnt - f0, 32'd1);
      check_eq("s5_key", {24'd0, key_pressed}, 32'h75);
      exp_q.push_back(8'h75);
      send_byte(8'h75);
      repeat (100) @(negedge clk);
      check_eq("s5_repress_flags", flag_cnt - f0, 32'd2);
      check_eq("s5_errs", err_cnt - e0, 32'd0);

      // reset in the middle of a frame
      mark();
      send_frame(8'h1C, 1'b0, 7);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("s6_rst_key", {24'd0, key_pressed}, 32'h00);
      check_eq("s6_rst_flag", {31'd0, key_flag}, 32'd0);
      check_eq("s6_rst_state", {30'd0, rx_state}, 32'd0);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      exp_q.push_back(8'h3B);
      send_byte(8'h3B);
      repeat (100) @(negedge clk);
      check_eq("s6_flags", flag_cnt - f0, 32'd1);
      check_eq("s6_errs", err_cnt - e0, 32'd0);
      check_eq("s6_key", {24'd0, key_pressed}, 32'h3B);
      check_eq("exp_q_drained", exp_q.size(), 32'd0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
